bbs_sched: RTL and testbench

Sequencing and sharing controller for the Blum-Blum-Shub generator `bbs_top`.
- Owns the generator's reseed/seed inputs: takes seeds from an upstream handshake, pulses reseed, discards warm-up bits and reseeds after a fixed number of delivered bits.
- Packs the generator's serial `out_valid`/`out_bit` stream into words.
- Hands each word to one of `NREQ` requesters under round-robin arbitration.
- Sits between `bbs_top` and the random-number consumers.

---
 rtl/bbs_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/bbs_sched.sv | 173 +++++++++++++++++
 tb/tb_bbs_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbs_pkg.sv
// Shared types and default parameters for the Blum-Blum-Shub sequencing controller.
package bbs_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESEED,
    S_WARM,
    S_RUN,
    S_WAIT_SEED
  } bbs_sched_state_t;

  localparam int unsigned BBS_W               = 16;
  localparam int unsigned BBS_WORD            = 8;
  localparam int unsigned BBS_NREQ            = 4;
  localparam int unsigned BBS_RESEED_INTERVAL = 1024;
  localparam int unsigned BBS_DISCARD         = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at the pointer, which
// advances past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt_next,
  output logic [PW-1:0]   ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    gnt_next = '0;
    idx      = '0;
    win      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr_q) + i) % NREQ);
      if (en && !found && req[idx]) begin
        found         = 1'b1;
        win           = idx;
        gnt_next[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (32'(win) + 32'd1 == NREQ) ? '0 : win + 1'b1;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/bbs_sched.sv
// Seeds and sequences bbs_top, packs its serial bit stream into words and hands
// each word to one requester under round-robin arbitration.
module bbs_sched
  import bbs_pkg::*;
#(
  parameter int unsigned W               = BBS_W,
  parameter int unsigned WORD            = BBS_WORD,
  parameter int unsigned NREQ            = BBS_NREQ,
  parameter int unsigned RESEED_INTERVAL = BBS_RESEED_INTERVAL,
  parameter int unsigned DISCARD         = BBS_DISCARD
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [W-1:0]    seed_in,
  input  logic            seed_valid,
  output logic            seed_ready,
  output logic            bbs_reseed,
  output logic [W-1:0]    bbs_seed,
  input  logic            bbs_valid,
  input  logic            bbs_bit,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [WORD-1:0] rd_data,
  output logic            seed_err,
  output logic [15:0]     drop_cnt
);

  localparam int unsigned PCW = $clog2(WORD + 1);
  localparam int unsigned WCW = $clog2(DISCARD + 2);
  localparam int unsigned ICW = $clog2(RESEED_INTERVAL + 1);
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  bbs_sched_state_t state_q;
  logic [W-1:0]     seed_q;
  logic             reseed_q, ready_q, err_q;
  logic [NREQ-1:0]  gnt_q;
  logic [WORD-1:0]  rd_q;
  logic [15:0]      drop_q;
  logic [WORD-1:0]  pack_q, hold_q;
  logic [PCW-1:0]   pack_cnt_q;
  logic             hold_vld_q;
  logic [WCW-1:0]   warm_cnt_q;
  logic [ICW-1:0]   int_cnt_q;

  logic             fire, hold_free, pack_full, run_bit, drop, accept, word_done;
  logic             seed_hs, seed_bad;
  logic [WORD-1:0]  pack_shift;
  logic [NREQ-1:0]  gnt_next;
  logic [PW-1:0]    arb_ptr_unused;

  always_comb begin
    fire       = hold_vld_q && (|req);
    hold_free  = !hold_vld_q || fire;
    pack_full  = (pack_cnt_q == PCW'(WORD));
    run_bit    = (state_q == S_RUN) && bbs_valid;
    drop       = run_bit && pack_full && !hold_free;
    accept     = run_bit && !drop;
    word_done  = accept && (pack_cnt_q == PCW'(WORD - 1));
    pack_shift = {pack_q[WORD-2:0], bbs_bit};
    seed_hs    = seed_valid && ready_q;
    seed_bad   = (seed_in[W-1:1] == '0);
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .en      (hold_vld_q),
    .gnt_next(gnt_next),
    .ptr     (arb_ptr_unused)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      seed_q     <= '0;
      reseed_q   <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      warm_cnt_q <= '0;
      int_cnt_q  <= '0;
    end else begin
      reseed_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_IDLE, S_WAIT_SEED: begin
          ready_q <= 1'b1;
          if (seed_hs && seed_bad) begin
            err_q <= 1'b1;
          end else if (seed_hs) begin
            seed_q   <= seed_in;
            reseed_q <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= S_RESEED;
          end
        end
        S_RESEED: begin
          warm_cnt_q <= '0;
          int_cnt_q  <= '0;
          state_q    <= (DISCARD == 0) ? S_RUN : S_WARM;
        end
        S_WARM: begin
          if (bbs_valid) begin
            if (warm_cnt_q == WCW'(DISCARD - 1)) state_q <= S_RUN;
            warm_cnt_q <= warm_cnt_q + WCW'(1);
          end
        end
        S_RUN: begin
          if (accept) begin
            int_cnt_q <= int_cnt_q + ICW'(1);
            if (int_cnt_q == ICW'(RESEED_INTERVAL - 1)) begin
              state_q <= S_WAIT_SEED;
              ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A full packer is a finished word waiting for the holding register; only a
  // partial word is thrown away on reseed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= '0;
      rd_q       <= '0;
      drop_q     <= '0;
      pack_q     <= '0;
      pack_cnt_q <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      gnt_q <= fire ? gnt_next : '0;
      if (fire) rd_q <= hold_q;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;

      if (pack_full && hold_free) begin
        hold_q     <= pack_q;
        hold_vld_q <= 1'b1;
        if (accept) begin
          pack_q     <= pack_shift;
          pack_cnt_q <= PCW'(1);
        end else begin
          pack_cnt_q <= '0;
        end
      end else if (word_done && hold_free) begin
        hold_q     <= pack_shift;
        hold_vld_q <= 1'b1;
        pack_cnt_q <= '0;
      end else begin
        if (fire) hold_vld_q <= 1'b0;
        if ((state_q == S_RESEED) && !pack_full) begin
          pack_cnt_q <= '0;
        end else if (accept) begin
          pack_q     <= pack_shift;
          pack_cnt_q <= pack_cnt_q + PCW'(1);
        end
      end
    end
  end

  assign seed_ready = ready_q;
  assign bbs_reseed = reseed_q;
  assign bbs_seed   = seed_q;
  assign gnt        = gnt_q;
  assign rd_data    = rd_q;
  assign seed_err   = err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_bbs_sched.sv
// Bench for bbs_sched: queue-based behavioural model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_bbs_sched;

  localparam int W    = 16;
  localparam int WORD = 8;
  localparam int NREQ = 4;
  localparam int RI   = 32;
  localparam int DISC = 16;

  localparam int P_IDLE = 0, P_RESEED = 1, P_WARM = 2, P_RUN = 3, P_WAIT = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [W-1:0]    seed_in;
  logic            seed_valid;
  logic            seed_ready;
  logic            bbs_reseed;
  logic [W-1:0]    bbs_seed;
  logic            bbs_valid;
  logic            bbs_bit;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [WORD-1:0] rd_data;
  logic            seed_err;
  logic [15:0]     drop_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  bbs_sched #(
    .W              (W),
    .WORD           (WORD),
    .NREQ           (NREQ),
    .RESEED_INTERVAL(RI),
    .DISCARD        (DISC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seed_in   (seed_in),
    .seed_valid(seed_valid),
    .seed_ready(seed_ready),
    .bbs_reseed(bbs_reseed),
    .bbs_seed  (bbs_seed),
    .bbs_valid (bbs_valid),
    .bbs_bit   (bbs_bit),
    .req       (req),
    .gnt       (gnt),
    .rd_data   (rd_data),
    .seed_err  (seed_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words waiting for delivery live in wq (at most two: the
  // holding register and a completed packer), partial bits in part.
  int          m_phase, warm_left, acc, m_ptr, m_win;
  logic        exp_ready, exp_reseed, exp_err;
  logic [15:0] exp_seed;
  logic [3:0]  exp_gnt;
  logic [7:0]  exp_rd, m_word;
  int          exp_drop;
  logic [7:0]  wq[$];
  bit          part[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = P_IDLE; exp_ready = 0; exp_reseed = 0; exp_err = 0; exp_seed = 0;
      exp_gnt = 0; exp_rd = 0; exp_drop = 0; warm_left = 0; acc = 0; m_ptr = 0;
      wq.delete(); part.delete();
    end else begin
      exp_reseed = 0; exp_err = 0; exp_gnt = 0;
      if (wq.size() != 0 && req != 0) begin
        m_win = -1;
        for (int k = 0; k < NREQ; k++)
          if (m_win < 0 && req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
        exp_gnt[m_win] = 1'b1;
        exp_rd = wq.pop_front();
        m_ptr = (m_win + 1) % NREQ;
      end
      case (m_phase)
        P_IDLE, P_WAIT: begin
          if (seed_valid && exp_ready && seed_in > 1) begin
            exp_seed = seed_in; exp_reseed = 1; exp_ready = 0; m_phase = P_RESEED;
          end else begin
            exp_err = seed_valid && exp_ready;
            exp_ready = 1;
          end
        end
        P_RESEED: begin
          part.delete(); warm_left = DISC; acc = 0; m_phase = P_WARM;
        end
        P_WARM: if (bbs_valid) begin
          warm_left--;
          if (warm_left == 0) m_phase = P_RUN;
        end
        P_RUN: if (bbs_valid) begin
          if (wq.size() == 2) begin
            if (exp_drop < 65535) exp_drop++;
          end else begin
            part.push_back(bbs_bit);
            acc++;
            if (part.size() == WORD) begin
              m_word = 0;
              foreach (part[i]) m_word = {m_word[6:0], part[i]};
              wq.push_back(m_word);
              part.delete();
            end
            if (acc == RI) begin
              m_phase = P_WAIT; exp_ready = 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  int log_idx[$];
  logic [7:0] log_dat[$];

  always begin
    @(posedge clk);
    #1;
    check("seed_ready", 32'(seed_ready), 32'(exp_ready));
    check("bbs_reseed", 32'(bbs_reseed), 32'(exp_reseed));
    check("bbs_seed", 32'(bbs_seed), 32'(exp_seed));
    check("seed_err", 32'(seed_err), 32'(exp_err));
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("rd_data", 32'(rd_data), 32'(exp_rd));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    if (gnt != 0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) log_idx.push_back(i);
      log_dat.push_back(rd_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bbs_valid = 1'b1; bbs_bit = b;
    @(negedge clk);
    bbs_valid = 1'b0; bbs_bit = 1'b0;
  endtask

  task automatic send_n(input int n, input logic b);
    repeat (n) send_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      idle(gap);
    end
  endtask

  task automatic offer_seed(input logic [15:0] s);
    int t;
    t = 0;
    while (!seed_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("seed_ready_wait", 32'(seed_ready), 32'd1);
    seed_in = s; seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
  endtask

  int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 3, 1};

  initial begin
    reset_n = 1'b0; seed_in = '0; seed_valid = 1'b0; bbs_valid = 1'b0; bbs_bit = 1'b0;
    req = '0;
    idle(3);
    check("rst_seed_ready", 32'(seed_ready), 32'd0);
    check("rst_bbs_seed", 32'(bbs_seed), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    reset_n = 1'b1;

    // Start-up, first word, interval reseed
    req = 4'b0001;
    offer_seed(16'd17827);
    check("start_reseed", 32'(bbs_reseed), 32'd1);
    check("start_seed", 32'(bbs_seed), 32'd17827);
    check("start_ready_low", 32'(seed_ready), 32'd0);
    send_bit(1'b1);
    check("reseed_one_cycle", 32'(bbs_reseed), 32'd0);
    send_n(DISC, 1'b0);
    send_byte(8'hA5, 0);
    idle(2);
    check("first_word_cnt", 32'(log_dat.size()), 32'd1);
    check("first_word_idx", 32'(log_idx[0]), 32'd0);
    check("first_word", 32'(log_dat[0]), 32'hA5);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    idle(2);
    check("interval_ready", 32'(seed_ready), 32'd1);
    send_byte(8'hFF, 0);
    idle(3);
    check("ignored_bits_cnt", 32'(log_dat.size()), 32'd4);
    check("word4", 32'(log_dat[3]), 32'h56);

    offer_seed(16'd1);
    check("rej_err", 32'(seed_err), 32'd1);
    check("rej_no_reseed", 32'(bbs_reseed), 32'd0);
    idle(1);
    check("rej_err_pulse", 32'(seed_err), 32'd0);
    offer_seed(16'd20051);
    check("reseed2_seed", 32'(bbs_seed), 32'd20051);
    check("reseed2_pulse", 32'(bbs_reseed), 32'd1);
    send_bit(1'b0);
    send_n(DISC, 1'b1);
    send_byte(8'h0F, 0);
    idle(2);
    check("post_reseed_cnt", 32'(log_dat.size()), 32'd5);
    check("post_reseed_word", 32'(log_dat[4]), 32'h0F);

    // Seed rejection from idle, then round-robin
    reset_n = 1'b0; idle(2); reset_n = 1'b1;
    log_idx.delete(); log_dat.delete();
    req = 4'b1111;
    offer_seed(16'd1);
    check("idle_rej_err", 32'(seed_err), 32'd1);
    check("idle_rej_no_reseed", 32'(bbs_reseed), 32'd0);
    offer_seed(16'd6661);
    check("rr_seed", 32'(bbs_seed), 32'd6661);
    check("rr_reseed", 32'(bbs_reseed), 32'd1);
    send_bit(1'b1);
    send_n(DISC, 1'b0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    idle(2);
    check("rr_wait_ready", 32'(seed_ready), 32'd1);
    offer_seed(16'd20051);
    send_bit(1'b0);
    send_n(DISC, 1'b0);
    send_byte(8'h05, 0);
    idle(2);
    req = 4'b1010;
    send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
    idle(2);
    check("rr_cnt", 32'(log_idx.size()), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), 32'(log_idx[i]), 32'(exp_rr[i]));
    check("rr_word5", 32'(log_dat[4]), 32'h05);

    // Overflow with no requesters
    reset_n = 1'b0; idle(2); reset_n = 1'b1;
    log_idx.delete(); log_dat.delete();
    req = 4'b0000;
    offer_seed(16'd17827);
    send_bit(1'b0);
    send_n(DISC, 1'b1);
    send_byte(8'h3C, 0);
    send_byte(8'hC3, 0);
    send_n(24, 1'b1);
    idle(2);
    check("ovf_drop", 32'(drop_cnt), 32'd24);
    check("ovf_no_grant", 32'(log_idx.size()), 32'd0);
    req = 4'b0100;
    idle(3);
    req = 4'b0000;
    check("ovf_grants", 32'(log_idx.size()), 32'd2);
    check("ovf_idx0", 32'(log_idx[0]), 32'd2);
    check("ovf_idx1", 32'(log_idx[1]), 32'd2);
    check("ovf_held_word", 32'(log_dat[0]), 32'h3C);
    check("ovf_pack_word", 32'(log_dat[1]), 32'hC3);
    check("ovf_drop_hold", 32'(drop_cnt), 32'd24);

    // Asynchronous reset mid-word
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_seed_ready", 32'(seed_ready), 32'd0);
    check("ar_reseed", 32'(bbs_reseed), 32'd0);
    check("ar_seed", 32'(bbs_seed), 32'd0);
    check("ar_gnt", 32'(gnt), 32'd0);
    check("ar_rd_data", 32'(rd_data), 32'd0);
    check("ar_err", 32'(seed_err), 32'd0);
    check("ar_drop", 32'(drop_cnt), 32'd0);
    check("ar_state", 32'(dut.state_q), 32'(bbs_pkg::S_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    check("ar_idle_ready", 32'(seed_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
